// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer for the single-port 64x64 data memory (IDLE -> ISSUE -> WAIT).
// Optional DMEM_ARB_FIXED_PRI_EN: requester 0 always wins contention; default is round-robin.
module data_memory_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t state, state_nx;
  cmd_t   cmd_q, cmd0, cmd1;
  logic   id_q;   // owner of the outstanding transaction (1 = requester 1)
  logic   win;    // arbitration result for this cycle (1 = requester 1)
  logic   take;

  assign cmd0 = '{rd: rd0, wr: wr0, addr: addr0, wdata: wdata0};
  assign cmd1 = '{rd: rd1, wr: wr1, addr: addr1, wdata: wdata1};

`ifdef DMEM_ARB_FIXED_PRI_EN
  assign win = ~req0;
`else
  logic last;
  // On contention the requester that did not win last time goes first.
  assign win = (req0 & req1) ? ~last : ~req0;

  always_ff @(posedge Clk) begin
    if (Rst)       last <= 1'b1;
    else if (take) last <= win;
  end
`endif

  always_comb begin
    state_nx  = state;
    take      = 1'b0;
    mem_en    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 | req1) begin
          take     = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en    = 1'b1;
        mem_read  = cmd_q.rd;
        mem_write = cmd_q.wr;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        // Reset arriving while the completion is pending swallows the done.
        done0    = ~id_q & ~Rst;
        done1    = id_q & ~Rst;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    rdata = (done0 | done1) ? mem_rdata : '0;
  end

  assign mem_address = cmd_q.addr;
  assign mem_wdata   = cmd_q.wdata;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      cmd_q <= '0;
      id_q  <= 1'b0;
    end else begin
      state <= state_nx;
      gnt0  <= take & ~win;
      gnt1  <= take & win;
      if (take) begin
        cmd_q <= win ? cmd1 : cmd0;
        id_q  <= win;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 64x64 registered-read memory.
module tb_data_memory_arbiter;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        req0, rd0, wr0, req1, rd1, wr1;
  logic [63:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, done0, gnt1, done1;
  logic [63:0] rdata;
  logic        mem_en, mem_read, mem_write;
  logic [63:0] mem_address, mem_wdata, mem_rdata;
  logic        init;
  logic [63:0] mem [0:63];

  int n_chk  = 0;
  int n_pass = 0;

`ifdef DMEM_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  data_memory_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0),
    .req1(req1), .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1),
    .rdata(rdata),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  // Memory: write-then-read on the same edge, registered read data, no reset.
  always @(posedge Clk) begin
    if (init) begin
      mem[1]    <= 64'h1111;
      mem[2]    <= 64'h2222;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_write) mem[mem_address[5:0]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem_write ? mem_wdata : mem[mem_address[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit rd, input bit wr,
                       input logic [63:0] a, input logic [63:0] wd);
    if (!id) begin req0 = 1; rd0 = rd; wr0 = wr; addr0 = a; wdata0 = wd; end
    else     begin req1 = 1; rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd; end
  endtask

  // One complete transaction from an idle arbiter with a single requester.
  task automatic xact(input bit id, input bit rd, input bit wr, input logic [63:0] a,
                      input logic [63:0] wd, input bit ck, input logic [63:0] exp);
    drive(id, rd, wr, a, wd);
    step();
    chk("gnt", id ? gnt1 : gnt0, 1);
    chk("gnt_other", id ? gnt0 : gnt1, 0);
    chk("issue_en", mem_en, 1);
    chk("issue_rw", {mem_read, mem_write}, {rd, wr});
    chk("issue_addr", mem_address, a);
    chk("issue_wdata", mem_wdata, wd);
    req0 = 0; req1 = 0;
    step();
    chk("done", id ? done1 : done0, 1);
    chk("done_other", id ? done0 : done1, 0);
    chk("wait_en", mem_en, 0);
    if (ck) chk("rdata", rdata, exp);
    step();
    chk("done_fall", {done0, done1}, 0);
  endtask

  initial begin
    Rst = 1; init = 1;
    req0 = 0; rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    step(); step();
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_done", {done0, done1}, 0);
    chk("rst_mem_ctl", {mem_en, mem_read, mem_write}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    Rst = 0; init = 0;
    step();
    chk("idle_gnt", {gnt0, gnt1}, 0);

    // r0 write then read back.
    xact(0, 0, 1, 64'd5, 64'hA5, 0, 0);
    chk("mem5", mem[5], 64'hA5);
    xact(0, 1, 0, 64'd5, 64'h0, 1, 64'hA5);
    chk("hold_addr", mem_address, 64'd5);

    // No-op command is still sequenced.
    xact(0, 0, 0, 64'd7, 64'h0, 0, 0);

    // r1 write+read: read data is the written data.
    xact(1, 1, 1, 64'd9, 64'h1234, 1, 64'h1234);
    chk("mem9", mem[9], 64'h1234);

    // Both requesters held; last grant was r1 so r0 leads.
    drive(0, 1, 0, 64'd1, 64'h0);
    drive(1, 1, 0, 64'd2, 64'h0);
    for (int k = 0; k < 4; k++) begin
      bit w;
      w = FIXED ? 1'b0 : k[0];
      step();
      chk("cont_gnt", {gnt1, gnt0}, w ? 2'b10 : 2'b01);
      chk("cont_addr", mem_address, w ? 64'd2 : 64'd1);
      step();
      chk("cont_done", {done1, done0}, w ? 2'b10 : 2'b01);
      chk("cont_rdata", rdata, w ? 64'h2222 : 64'h1111);
      step();
      chk("cont_gap", {gnt0, gnt1, done0, done1}, 0);
    end
    req0 = 0;
    step();
    chk("r1_after_drop", {gnt1, gnt0}, 2'b10);
    req1 = 0;
    step();
    chk("r1_after_done", done1, 1);
    chk("r1_after_rdata", rdata, 64'h2222);
    step();

    // Reset during WAIT of an r0 read.
    drive(0, 1, 0, 64'd1, 64'h0);
    step();
    chk("rw_gnt", gnt0, 1);
    req0 = 0;
    step();
    Rst = 1;
    #1;
    chk("rw_done_supp", {done0, done1}, 0);
    chk("rw_rdata", rdata, 0);
    step();
    Rst = 0;
    #1;
    chk("rw_post_gnt", {gnt0, gnt1}, 0);
    chk("rw_post_done", {done0, done1}, 0);
    chk("rw_post_ctl", {mem_en, mem_read, mem_write}, 0);
    chk("rw_post_addr", mem_address, 0);
    chk("rw_post_wdata", mem_wdata, 0);
    xact(1, 1, 0, 64'd2, 64'h0, 1, 64'h2222);

    // Reset during ISSUE of an r1 write: op still commits, no done.
    drive(1, 0, 1, 64'd3, 64'h77);
    step();
    chk("ri_gnt", gnt1, 1);
    chk("ri_en", mem_en, 1);
    req1 = 0;
    Rst = 1;
    step();
    Rst = 0;
    #1;
    chk("ri_done", {done0, done1}, 0);
    chk("ri_en_off", mem_en, 0);
    step();
    chk("ri_done_late", {done0, done1}, 0);
    chk("ri_mem3", mem[3], 64'h77);
    xact(0, 1, 0, 64'd3, 64'h0, 1, 64'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
